// File: rtl/lsu_pkg.sv
// Shared funct3 encodings, FSM state type and access-size helpers for the load/store unit.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ADDR  = 3'd1,
      S_READ  = 3'd2,
      S_WRITE = 3'd3,
      S_RESP  = 3'd4
   } state_e;

   function automatic logic f3_illegal(input logic store, input logic [2:0] f3);
      if (store) return !(f3 inside {F3_B, F3_H, F3_W});
      return !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
   endfunction

   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
      case (f3)
         F3_H, F3_HU: return off[0];
         F3_W:        return off != 2'd0;
         default:     return 1'b0;
      endcase
   endfunction

   // Byte offset actually used: halfwords drop bit 0, words always start at lane 0.
   function automatic logic [1:0] eff_off(input logic [2:0] f3, input logic [1:0] off);
      case (f3)
         F3_H, F3_HU: return {off[1], 1'b0};
         F3_W:        return 2'd0;
         default:     return off;
      endcase
   endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Request/response handshake and data-memory port of the load/store control stage.
interface lsu_ctrl_if #(
   parameter int ADDR_W = 9
);
   logic              req_valid;
   logic              req_ready;
   logic              req_store;
   logic [2:0]        req_funct3;
   logic [31:0]       req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic              resp_ready;
   logic [31:0]       resp_rdata;
   logic              resp_err;
   logic [ADDR_W-1:0] mem_addr;
   logic [3:0]        mem_we;
   logic              mem_rd;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   modport slave (
      input  req_valid, req_store, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_we, mem_rd, mem_wdata
   );

   modport master (
      output req_valid, req_store, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_we, mem_rd, mem_wdata
   );
endinterface

// File: rtl/lsu_align.sv
// Combinational store-lane alignment (request side) and load extract/extend (response side).
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  st_funct3_i,
   input  logic [1:0]  st_off_i,
   input  logic [31:0] st_data_i,
   output logic [3:0]  st_we_o,
   output logic [31:0] st_data_o,
   input  logic [2:0]  ld_funct3_i,
   input  logic [1:0]  ld_off_i,
   input  logic [31:0] ld_rdata_i,
   output logic [31:0] ld_data_o
);
   logic [15:0] ld_shift;

   always_comb begin
      st_we_o   = 4'b1111;
      st_data_o = st_data_i;
      case (st_funct3_i)
         F3_B: begin
            st_we_o   = 4'b0001 << st_off_i;
            st_data_o = {4{st_data_i[7:0]}};
         end
         F3_H: begin
            st_we_o   = 4'b0011 << st_off_i;
            st_data_o = {2{st_data_i[15:0]}};
         end
         default: ;
      endcase
   end

   assign ld_shift = 16'(ld_rdata_i >> {ld_off_i, 3'b000});

   always_comb begin
      ld_data_o = ld_rdata_i;
      case (ld_funct3_i)
         F3_B:    ld_data_o = {{24{ld_shift[7]}}, ld_shift[7:0]};
         F3_BU:   ld_data_o = {24'd0, ld_shift[7:0]};
         F3_H:    ld_data_o = {{16{ld_shift[15]}}, ld_shift};
         F3_HU:   ld_data_o = {16'd0, ld_shift};
         default: ;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control: request capture, two-cycle memory read sequencing and response hold.
// Build option: define MISALIGN_TRAP_EN to trap misaligned halfword/word accesses instead of aligning them down.
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 9
) (
   input  logic       clk,
   input  logic       rst,
   lsu_ctrl_if.slave  bus
);
   state_e            state_q, state_d;
   logic              accept;
   logic              req_err;
   logic [1:0]        req_off;
   logic [3:0]        st_we;
   logic [31:0]       st_data;
   logic [31:0]       ld_data;
   logic              store_q, err_q;
   logic [2:0]        funct3_q;
   logic [1:0]        off_q;
   logic [ADDR_W-1:0] addr_q;
   logic [3:0]        we_q;
   logic [31:0]       wdata_q;
   logic              unused_addr;

   assign unused_addr = ^bus.req_addr[31:ADDR_W+2];
   assign req_off     = eff_off(bus.req_funct3, bus.req_addr[1:0]);
`ifdef MISALIGN_TRAP_EN
   assign req_err = f3_illegal(bus.req_store, bus.req_funct3) |
                    misaligned(bus.req_funct3, bus.req_addr[1:0]);
`else
   assign req_err = f3_illegal(bus.req_store, bus.req_funct3);
`endif
   assign accept = (state_q == S_IDLE) && bus.req_valid;

   lsu_align u_align (
      .st_funct3_i (bus.req_funct3),
      .st_off_i    (req_off),
      .st_data_i   (bus.req_wdata),
      .st_we_o     (st_we),
      .st_data_o   (st_data),
      .ld_funct3_i (funct3_q),
      .ld_off_i    (off_q),
      .ld_rdata_i  (bus.mem_rdata),
      .ld_data_o   (ld_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         store_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            addr_q  <= bus.req_addr[ADDR_W+1:2];
            store_q <= bus.req_store;
            err_q   <= req_err;
         end
      end
   end

   // Datapath capture is only observed after an accept, so it carries no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         funct3_q <= bus.req_funct3;
         off_q    <= req_off;
         we_q     <= st_we;
         wdata_q  <= st_data;
      end
   end

   always_comb begin
      state_d        = state_q;
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      bus.resp_err   = 1'b0;
      bus.resp_rdata = '0;
      bus.mem_we     = '0;
      bus.mem_rd     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid)
               state_d = req_err ? S_RESP : (bus.req_store ? S_WRITE : S_ADDR);
         end
         S_ADDR:  state_d = S_READ;
         S_READ: begin
            bus.mem_rd = 1'b1;
            state_d    = S_RESP;
         end
         S_WRITE: begin
            bus.mem_we = we_q;
            state_d    = S_RESP;
         end
         S_RESP: begin
            bus.resp_valid = 1'b1;
            bus.resp_err   = err_q;
            bus.resp_rdata = (store_q || err_q) ? 32'd0 : ld_data;
            if (bus.resp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomised bench for lsu_ctrl: transaction-level reference model, per-cycle output compare, two-cycle memory.
// Define MISALIGN_TRAP_EN for both RTL and bench to check the trapping variant.
module tb_lsu_ctrl;
   localparam int ADDR_W = 9;
   localparam int DEPTH  = 1 << ADDR_W;

   logic clk = 1'b0;
   logic rst;
   int   vectors     = 0;
   int   miscompares = 0;

   lsu_ctrl_if #(.ADDR_W(ADDR_W)) bus ();
   lsu_ctrl #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] init_word(input int i);
      if (i == 1) return 32'h80FF_7F01;
      return 32'(i) * 32'h9E37_79B1 ^ 32'h5A5A_1234;
   endfunction

   // Data memory: address register every cycle, output register loaded by mem_rd.
   logic [31:0]       ram [DEPTH];
   logic [ADDR_W-1:0] ram_addr_q;
   logic [31:0]       ram_dout;
   assign bus.mem_rdata = ram_dout;

   initial begin
      for (int i = 0; i < DEPTH; i++) ram[i] = init_word(i);
      ram_dout   = '0;
      ram_addr_q = '0;
      forever begin
         @(posedge clk);
         ram_addr_q <= bus.mem_addr;
         if (bus.mem_rd) ram_dout <= ram[ram_addr_q];
         for (int b = 0; b < 4; b++)
            if (bus.mem_we[b]) ram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end
   end

   // Reference model state (kind: 0 load, 1 store, 2 error)
   logic [31:0]       ref_mem [DEPTH];
   bit                busy, started;
   int                cyc, lat, kind;
   logic [3:0]        m_we;
   logic [31:0]       m_wdata, m_rdata;
   logic              m_err;
   logic [ADDR_W-1:0] m_waddr;

   task automatic model_accept(input logic st, input logic [2:0] f3_l, input logic [31:0] addr, input logic [31:0] rs2);
      int f, size, off;
      bit illegal, mis;
      longint v;
      f       = int'(f3_l);
      size    = (f % 4 == 0) ? 1 : (f % 4 == 1) ? 2 : 4;
      illegal = st ? (f > 2) : (f == 3 || f > 5);
      off     = int'(addr % 4);
      mis     = (off % size) != 0;
`ifdef MISALIGN_TRAP_EN
      m_err = illegal || mis;
`else
      m_err = illegal;
`endif
      off     = off - off % size;
      m_waddr = ADDR_W'(addr / 4);
      kind    = m_err ? 2 : (st ? 1 : 0);
      lat     = 3 - kind;
      m_we    = '0;
      m_wdata = '0;
      m_rdata = '0;
      if (kind == 1) begin
         for (int b = 0; b < 4; b++) begin
            m_wdata[8*b +: 8] = rs2[8*(b % size) +: 8];
            if (b >= off && b < off + size) begin
               m_we[b] = 1'b1;
               ref_mem[m_waddr][8*b +: 8] = m_wdata[8*b +: 8];
            end
         end
      end else if (kind == 0) begin
         v = longint'({32'd0, ref_mem[m_waddr]});
         v = (v >> (8 * off)) & ((longint'(1) << (8 * size)) - 1);
         if (f < 4 && size < 4 && v >= (longint'(1) << (8 * size - 1)))
            v = v - (longint'(1) << (8 * size));
         m_rdata = v[31:0];
      end
      busy = 1'b1;
      cyc  = 1;
   endtask

   // Advance the model on each edge, then compare every output just after it.
   initial begin
      bit rv;
      logic [3:0] exp_we;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
      busy = 1'b0; started = 1'b0; cyc = 0; lat = 1; kind = 0;
      m_waddr = '0; m_err = 1'b0; m_we = '0; m_wdata = '0; m_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            busy    = 1'b0;
            m_waddr = '0;
            started = 1'b1;
         end else if (busy) begin
            if (cyc >= lat && bus.resp_ready) busy = 1'b0;
            else cyc++;
         end else if (bus.req_valid) begin
            model_accept(bus.req_store, bus.req_funct3, bus.req_addr, bus.req_wdata);
         end
         if (started) begin
            rv     = busy && cyc >= lat;
            exp_we = (busy && kind == 1 && cyc == 1) ? m_we : 4'd0;
            chk("req_ready", 32'(bus.req_ready), 32'(!busy));
            chk("resp_valid", 32'(bus.resp_valid), 32'(rv));
            if (rv || rst) begin
               chk("resp_err", 32'(bus.resp_err), 32'(rv && m_err));
               chk("resp_rdata", bus.resp_rdata, rv ? m_rdata : 32'd0);
            end
            chk("mem_we", 32'(bus.mem_we), 32'(exp_we));
            chk("mem_rd", 32'(bus.mem_rd), 32'(busy && kind == 0 && cyc == 2));
            chk("mem_addr", 32'(bus.mem_addr), 32'(m_waddr));
            if (exp_we != 4'd0) chk("mem_wdata", bus.mem_wdata, m_wdata);
         end
      end
   end

   int                t_lat;
   logic [31:0]       t_rd, t_wd1;
   logic              t_err;
   logic [3:0]        t_we1;
   logic [ADDR_W-1:0] t_a1;

   // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
   task automatic do_req(input logic st, input logic [2:0] f3_l, input logic [31:0] addr,
                         input logic [31:0] wd, input int hold);
      int n;
      bus.req_valid  = 1'b1;
      bus.req_store  = st;
      bus.req_funct3 = f3_l;
      bus.req_addr   = addr;
      bus.req_wdata  = wd;
      bus.resp_ready = 1'b0;
      @(negedge clk);
      bus.req_valid = 1'b0;
      n     = 1;
      t_we1 = bus.mem_we;
      t_wd1 = bus.mem_wdata;
      t_a1  = bus.mem_addr;
      while (!bus.resp_valid && n < 20) begin
         bus.resp_ready = 1'($urandom % 2);
         @(negedge clk);
         n++;
      end
      t_lat = n;
      t_rd  = bus.resp_rdata;
      t_err = bus.resp_err;
      if (!bus.resp_valid) begin
         vectors++;
         miscompares++;
         $display("FAIL resp_timeout: no resp_valid within %0d cycles", n);
         bus.resp_ready = 1'b0;
         return;
      end
      bus.resp_ready = 1'b0;
      repeat (hold) @(negedge clk);
      bus.resp_ready = 1'b1;
      @(negedge clk);
      bus.resp_ready = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       st;
      logic [2:0] f3;
      logic [31:0] addr;
      rst = 1'b1;
      bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_funct3 = 3'd0;
      bus.req_addr = '0; bus.req_wdata = '0; bus.resp_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      do_req(1'b0, 3'd0, 32'h6, 32'h0, 0);
      chk("lb_lat", 32'(t_lat), 32'd3);
      chk("lb_data", t_rd, 32'hFFFF_FFFF);
      do_req(1'b0, 3'd4, 32'h7, 32'h0, 0);
      chk("lbu_data", t_rd, 32'h0000_0080);
      do_req(1'b0, 3'd1, 32'h4, 32'h0, 1);
      chk("lh_data", t_rd, 32'h0000_7F01);
      do_req(1'b0, 3'd2, 32'h4, 32'h0, 0);
      chk("lw_lat", 32'(t_lat), 32'd3);
      chk("lw_data", t_rd, 32'h80FF_7F01);
      do_req(1'b0, 3'd1, 32'h5, 32'h0, 0);
`ifdef MISALIGN_TRAP_EN
      chk("lh_mis_lat", 32'(t_lat), 32'd1);
      chk("lh_mis_err", 32'(t_err), 32'd1);
      chk("lh_mis_data", t_rd, 32'd0);
`else
      chk("lh_mis_lat", 32'(t_lat), 32'd3);
      chk("lh_mis_err", 32'(t_err), 32'd0);
      chk("lh_mis_data", t_rd, 32'h0000_7F01);
`endif
      do_req(1'b1, 3'd0, 32'h6, 32'h0000_00A5, 0);
      chk("sb_lat", 32'(t_lat), 32'd2);
      chk("sb_we", 32'(t_we1), 32'h4);
      chk("sb_wdata", t_wd1, 32'hA5A5_A5A5);
      chk("sb_addr", 32'(t_a1), 32'd1);
      chk("sb_rdata", t_rd, 32'd0);
      do_req(1'b1, 3'd3, 32'h8, 32'hDEAD_BEEF, 0);
      chk("st_ill_lat", 32'(t_lat), 32'd1);
      chk("st_ill_err", 32'(t_err), 32'd1);
      chk("st_ill_we", 32'(t_we1), 32'd0);
      do_req(1'b0, 3'd2, 32'h4, 32'h0, 5);
      chk("lw_after_sb", t_rd, 32'h80A5_7F01);

      // Reset during the READ cycle of a load drops it without a response.
      bus.req_valid = 1'b1; bus.req_store = 1'b0; bus.req_funct3 = 3'd2;
      bus.req_addr = 32'h8; bus.req_wdata = '0;
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_mem_rd", 32'(bus.mem_rd), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
      chk("post_rst_mem_rd", 32'(bus.mem_rd), 32'd0);
      for (int i = 0; i < 4; i++) begin
         chk("post_rst_no_resp", 32'(bus.resp_valid), 32'd0);
         @(negedge clk);
      end
      do_req(1'b1, 3'd2, 32'h10, 32'h1234_5678, 0);
      chk("sw_lat", 32'(t_lat), 32'd2);
      chk("sw_we", 32'(t_we1), 32'hF);
      chk("sw_err", 32'(t_err), 32'd0);
      do_req(1'b0, 3'd2, 32'h10, 32'h0, 0);
      chk("lw_after_sw", t_rd, 32'h1234_5678);

      for (int t = 0; t < 400; t++) begin
         st = 1'($urandom % 2);
         if ($urandom % 5 == 0) f3 = 3'($urandom % 8);
         else if (st) f3 = 3'($urandom % 3);
         else begin
            case ($urandom % 5)
               0: f3 = 3'd0;
               1: f3 = 3'd1;
               2: f3 = 3'd2;
               3: f3 = 3'd4;
               default: f3 = 3'd5;
            endcase
         end
         addr = ($urandom & 32'hFFFF_F800) | (($urandom % 8) << 2) | ($urandom % 4);
         do_req(st, f3, addr, $urandom, int'($urandom % 4));
         repeat ($urandom % 2) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
